// File: rtl/dct_output_serializer.sv
// ============================================================================
// Module  : dct_output_serializer
// Purpose : Captures a stage-4 DCT frame, rounds/saturates it into natural
//           X0..X7 order and streams it out over valid/ready (ping-pong).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dct_output_serializer #(
    parameter int FRAC  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      r0,
    input  logic [10:0]      r1,
    input  logic [25:0]      r2,
    input  logic [25:0]      r3,
    input  logic [26:0]      r4,
    input  logic [26:0]      r5,
    input  logic [26:0]      r6,
    input  logic [26:0]      r7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_idx,
    output logic             out_last
);

    localparam logic [0:0] c_idle   = 1'b0;
    localparam logic [0:0] c_stream = 1'b1;

    localparam logic signed [27:0] c_half = 28'sd1 <<< (FRAC - 1);
    localparam logic signed [27:0] c_max  = (28'sd1 <<< (OUT_W - 1)) - 28'sd1;
    localparam logic signed [27:0] c_min  = -(28'sd1 <<< (OUT_W - 1));

    // Round half toward +inf, then clamp to the signed OUT_W range.
    function automatic logic [OUT_W-1:0] round_sat(input logic [26:0] v);
        logic signed [27:0] sum;
        logic signed [27:0] q;
        sum = $signed({v[26], v}) + c_half;
        q   = sum >>> FRAC;
        if (q > c_max)
            return c_max[OUT_W-1:0];
        else if (q < c_min)
            return c_min[OUT_W-1:0];
        else
            return q[OUT_W-1:0];
    endfunction

    logic [0:0]       r_state;
    logic [1:0]       r_full;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [2:0]       r_idx;
    logic [OUT_W-1:0] r_mem [2][8];

    logic [OUT_W-1:0] w_conv [8];
    logic [1:0]       w_full_nxt;
    logic             w_capture;
    logic             w_release;

    assign in_ready  = ~r_full[r_wr_ptr];
    assign out_valid = (r_state == c_stream);
    assign out_idx   = r_idx;
    assign out_last  = out_valid && (r_idx == 3'd7);
    assign out_data  = out_valid ? r_mem[r_rd_ptr][r_idx] : '0;

    assign w_capture = in_valid && in_ready;
    assign w_release = out_valid && out_ready && (r_idx == 3'd7);

    // Slot k of a bank holds coefficient Xk.
    always_comb begin
        w_conv[0] = {{(OUT_W-11){r0[10]}}, r0};
        w_conv[1] = round_sat(r7);
        w_conv[2] = round_sat({r2[25], r2});
        w_conv[3] = round_sat(r5);
        w_conv[4] = {{(OUT_W-11){r1[10]}}, r1};
        w_conv[5] = round_sat(r6);
        w_conv[6] = round_sat({r3[25], r3});
        w_conv[7] = round_sat(r4);
    end

    // Capture and release never target the same bank on one edge.
    always_comb begin
        w_full_nxt = r_full;
        if (w_capture)
            w_full_nxt[r_wr_ptr] = 1'b1;
        if (w_release)
            w_full_nxt[r_rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < 8; k++)
                r_mem[r_wr_ptr][k] <= w_conv[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_idle;
            r_full   <= 2'b00;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_idx    <= 3'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_capture)
                r_wr_ptr <= ~r_wr_ptr;
            case (r_state)
                c_idle: begin
                    if (r_full[r_rd_ptr]) begin
                        r_state <= c_stream;
                        r_idx   <= 3'd0;
                    end
                end
                c_stream: begin
                    if (out_ready) begin
                        if (r_idx == 3'd7) begin
                            r_idx    <= 3'd0;
                            r_rd_ptr <= ~r_rd_ptr;
                            r_state  <= r_full[~r_rd_ptr] ? c_stream : c_idle;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dct_output_serializer.sv
// ============================================================================
// Module  : tb_dct_output_serializer
// Purpose : Self-checking bench for dct_output_serializer (16- and 12-bit).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dct_output_serializer;

    typedef struct {
        int r   [8];
        int e16 [8];
        int e12 [8];
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [10:0] r0, r1;
    logic [25:0] r2, r3;
    logic [26:0] r4, r5, r6, r7;

    logic        in_ready, out_valid, out_last;
    logic [15:0] out_data;
    logic [2:0]  out_idx;
    logic        in_ready12, out_valid12, out_last12;
    logic [11:0] out_data12;
    logic [2:0]  out_idx12;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t vecs [4];
    int   c1, c2, c3, ft, bub, n;

    dct_output_serializer #(.FRAC(8), .OUT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    dct_output_serializer #(.FRAC(8), .OUT_W(12)) u_dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready12),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .out_valid(out_valid12), .out_ready(out_ready), .out_data(out_data12),
        .out_idx(out_idx12), .out_last(out_last12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic put_frame(input vec_t v, input bit keep, output int cap);
        int w;
        r0 = 11'(v.r[0]); r1 = 11'(v.r[1]);
        r2 = 26'(v.r[2]); r3 = 26'(v.r[3]);
        r4 = 27'(v.r[4]); r5 = 27'(v.r[5]);
        r6 = 27'(v.r[6]); r7 = 27'(v.r[7]);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("capture_wait", int'(w < 50), 1);
        cap = cyc;
        @(negedge clk);
        if (!keep)
            in_valid = 1'b0;
    endtask

    // Consumes nfr frames starting at vecs[base], checking order, hold and last.
    task automatic collect(input int base, input int nfr, input bit bp,
                           output int first_t, output int bubbles);
        bit pat [4];
        int k, t;
        bit rdy, seen;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        k = 0; t = 0; seen = 0; bubbles = 0; first_t = -1;
        while (k < 8 * nfr && t < 200) begin
            rdy = bp ? pat[t % 4] : 1'b1;
            out_ready = rdy;
            if (out_valid) begin
                if (!seen) first_t = t;
                seen = 1;
                check($sformatf("idx[%0d]", k), int'(out_idx), k % 8);
                check($sformatf("data16[%0d]", k), $signed(out_data),
                      vecs[base + k / 8].e16[k % 8]);
                check($sformatf("data12[%0d]", k), $signed(out_data12),
                      vecs[base + k / 8].e12[k % 8]);
                check($sformatf("last[%0d]", k), int'(out_last), int'((k % 8) == 7));
                if (rdy) k++;
            end else if (seen) begin
                bubbles++;
            end
            t++;
            @(negedge clk);
        end
        check("collect_complete", k, 8 * nfr);
    endtask

    initial begin
        vecs[0].r   = '{100, -50, 640, -640, 0, -1000, 300, 2560};
        vecs[0].e16 = '{100, 10, 3, -4, -50, 1, -2, 0};
        vecs[0].e12 = '{100, 10, 3, -4, -50, 1, -2, 0};
        vecs[1].r   = '{-1024, 0, 0, 0, -600000, 0, 0, 600000};
        vecs[1].e16 = '{-1024, 2344, 0, 0, 0, 0, 0, -2344};
        vecs[1].e12 = '{-1024, 2047, 0, 0, 0, 0, 0, -2048};
        vecs[2].r   = '{1023, -1024, 128, -128, 383, 127, -129, -1280};
        vecs[2].e16 = '{1023, -5, 1, 0, -1024, -1, 0, 1};
        vecs[2].e12 = '{1023, -5, 1, 0, -1024, -1, 0, 1};
        vecs[3].r   = '{-1, 0, 33554431, -33554432, -67108864, 8388352, 8388480, 67108863};
        vecs[3].e16 = '{-1, 32767, 32767, 32767, 0, 32767, -32768, -32768};
        vecs[3].e12 = '{-1, 2047, 2047, 2047, 0, 2047, -2048, -2048};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0; r6 = '0; r7 = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid12", int'(out_valid12), 0);
        check("rst_in_ready12", int'(in_ready12), 1);
        check("rst_idx12_last12", int'({out_idx12, out_last12}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven single frames: conversion, rounding, saturation, latency.
        for (int i = 0; i < 4; i++) begin
            put_frame(vecs[i], 1'b0, c1);
            check($sformatf("vec%0d_valid_at_capture", i), int'(out_valid), 0);
            collect(i, 1, 1'b0, ft, bub);
            check($sformatf("vec%0d_first_latency", i), ft, 1);
            check($sformatf("vec%0d_idle_after", i), int'(out_valid), 0);
        end

        // Backpressure with ready pattern 1,0,0,1.
        put_frame(vecs[0], 1'b0, c1);
        collect(0, 1, 1'b1, ft, bub);
        check("bp_bubbles", bub, 0);
        check("bp_idle_after", int'(out_valid), 0);

        // Ping-pong: three frames back to back with in_valid held high.
        out_ready = 1'b1;
        fork
            begin
                put_frame(vecs[0], 1'b1, c1);
                put_frame(vecs[1], 1'b1, c2);
                put_frame(vecs[2], 1'b0, c3);
            end
            collect(0, 3, 1'b0, ft, bub);
        join
        check("pp_cap2_delay", c2 - c1, 1);
        check("pp_cap3_delay", c3 - c1, 10);
        check("pp_first_latency", ft, 2);
        check("pp_bubbles", bub, 0);
        check("pp_idle_after", int'(out_valid), 0);

        // Reset mid-stream with both banks full.
        out_ready = 1'b0;
        put_frame(vecs[0], 1'b1, c1);
        put_frame(vecs[1], 1'b0, c2);
        check("full_in_ready", int'(in_ready), 0);
        check("full_holds_x0", int'(out_idx), 0);
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_idx == 3'd4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx4", int'(n < 20), 1);
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_idx", int'(out_idx), 0);
        check("midrst_out_data", int'(out_data), 0);
        reset = 1'b0;
        @(negedge clk);
        check("postrst_no_stale", int'(out_valid), 0);
        put_frame(vecs[2], 1'b0, c1);
        collect(2, 1, 1'b0, ft, bub);
        check("postrst_first_latency", ft, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("postrst_idle%0d", i), int'(out_valid), 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
